bf_run_ctrl: RTL and testbench
==============================

BF_RUN_CTRL -- requirements
Module: bf_run_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (all state on rising edge).
REQ-002 SHALL have ports: resetq  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: ld_valid/ld_ready  in/out  1/1  program byte stream handshake; ld_data  in  8  instruction byte; ld_last  in  1  final byte of program.
REQ-004 SHALL have ports: start  in  1  rerun loaded program; abort  in  1  stop run or load; busy  out  1  not IDLE; done  out  1  one-cycle run-complete pulse.
REQ-005 SHALL have ports: code_we  out  1; code_waddr  out  `CADDR_WIDTH (13); code_wdata  out  8  code RAM write port.
REQ-006 SHALL have ports: core_resetq  out  1  core reset, active-low; core_code_addr  in  `CADDR_WIDTH  core next fetch address.
REQ-007 SHALL have ports: core_mem_addr  in  `DADDR_WIDTH (15), core_mem_wr  in  1, core_mem_dout  in  `DATA_WIDTH (8)  core tape port.
REQ-008 SHALL have ports: tape_addr  out  `DADDR_WIDTH, tape_we  out  1, tape_wdata  out  `DATA_WIDTH  tape RAM port.

Function
REQ-009 SHALL implement states IDLE, LOAD, CLEAR, RUN, DONE; encoding is implementation-defined.
REQ-010 ld_ready SHALL be 1 only in IDLE and LOAD; a beat is accepted when ld_valid&ld_ready at a clock edge.
REQ-011 Each accepted beat SHALL produce code_we=1, code_waddr=ld_cnt, code_wdata=ld_data in the same cycle (combinational), then ld_cnt+1.
REQ-012 IDLE: accepted beat SHALL clear ld_cnt to 0 before writing (first byte to address 0) and enter LOAD, or CLEAR if ld_last.
REQ-013 LOAD: beat with ld_last, or beat at ld_cnt=8191, SHALL latch prog_len=ld_cnt+1 and enter CLEAR; no wrap of code address.
REQ-014 IDLE: start with prog_len!=0 and no accepted beat SHALL enter CLEAR; start with prog_len=0 SHALL be ignored; beat and start together -> beat wins.
REQ-015 CLEAR: SHALL drive tape_we=1, tape_wdata=0, tape_addr=clr_cnt, clr_cnt from 0 to 32767, one address per cycle (32768 cycles), then enter RUN.
REQ-016 Outside CLEAR the tape port SHALL mirror core_mem_addr/core_mem_wr/core_mem_dout combinationally; tape_we SHALL be 0 outside CLEAR and RUN.
REQ-017 core_resetq SHALL be registered, 1 only in RUN; it rises on the edge entering RUN.
REQ-018 RUN: core_code_addr==prog_len sampled at an edge SHALL enter DONE and drop core_resetq at that edge.
REQ-019 DONE SHALL last exactly one cycle with done=1, then IDLE; prog_len SHALL be retained for rerun.
REQ-020 abort in LOAD SHALL set prog_len=0 and enter IDLE; in CLEAR or RUN SHALL enter IDLE with done=0, prog_len kept; abort has priority over all other events.
REQ-021 busy SHALL be 1 in LOAD, CLEAR, RUN, DONE.

Reset
REQ-022 resetq low SHALL asynchronously force IDLE, ld_cnt=0, clr_cnt=0, prog_len=0, core_resetq=0, done=0, busy=0; combinational outputs follow IDLE.
REQ-023 Reset mid-RUN or mid-CLEAR SHALL hold the core in reset; no partial state survives.

Structure
REQ-024 Widths SHALL come from the shared common.h (`CADDR_WIDTH, `DADDR_WIDTH, `DATA_WIDTH); state encoding SHALL be defined there as constants.
REQ-025 Block SHALL be a single module; no sub-module.

Verification
REQ-026 Load 3 bytes 0x01,0x02,0x03(last) -> code writes at 0,1,2; prog_len=3; CLEAR entered next cycle.
REQ-027 CLEAR -> exactly 32768 tape_we cycles, addresses 0..32767, data 0; core_resetq rises the following edge.
REQ-028 RUN with core_code_addr stepping to 3 -> core_resetq falls and done=1 for one cycle, busy falls next cycle.
REQ-029 start in IDLE after run -> CLEAR then RUN with same prog_len; start after reset (prog_len=0) -> stays IDLE.
REQ-030 abort at CLEAR cycle 100 -> IDLE, done never asserted, core_resetq stays 0; abort in LOAD -> prog_len=0.
REQ-031 8192 beats without ld_last -> last write at 8191, prog_len=8192, CLEAR entered.

Source files
------------

// File: rtl/bf_run_ctrl_pkg.sv
// Shared widths, limits and state encoding for the run controller.
package bf_run_ctrl_pkg;

  localparam int unsigned CADDR_WIDTH = 13;
  localparam int unsigned DADDR_WIDTH = 15;
  localparam int unsigned DATA_WIDTH  = 8;
  // One bit wider than the code address so a full 8192-byte program fits.
  localparam int unsigned PLEN_WIDTH  = CADDR_WIDTH + 1;
  localparam int unsigned ST_WIDTH    = 3;

  localparam logic [CADDR_WIDTH-1:0] CODE_LAST = '1;
  localparam logic [DADDR_WIDTH-1:0] CLR_LAST  = '1;

  localparam logic [ST_WIDTH-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_WIDTH-1:0] ST_LOAD  = 3'd1;
  localparam logic [ST_WIDTH-1:0] ST_CLEAR = 3'd2;
  localparam logic [ST_WIDTH-1:0] ST_RUN   = 3'd3;
  localparam logic [ST_WIDTH-1:0] ST_DONE  = 3'd4;

  // Any state other than IDLE counts as busy.
  function automatic logic st_busy(input logic [ST_WIDTH-1:0] st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/bf_run_ctrl.sv
// Program loader / tape clearer / run sequencer for the BF core.
module bf_run_ctrl
  import bf_run_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetq,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  input  logic                   ld_last,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   code_we,
  output logic [CADDR_WIDTH-1:0] code_waddr,
  output logic [DATA_WIDTH-1:0]  code_wdata,
  output logic                   core_resetq,
  input  logic [CADDR_WIDTH-1:0] core_code_addr,
  input  logic [DADDR_WIDTH-1:0] core_mem_addr,
  input  logic                   core_mem_wr,
  input  logic [DATA_WIDTH-1:0]  core_mem_dout,
  output logic [DADDR_WIDTH-1:0] tape_addr,
  output logic                   tape_we,
  output logic [DATA_WIDTH-1:0]  tape_wdata
);

  logic [ST_WIDTH-1:0]    r_state;
  logic [CADDR_WIDTH-1:0] r_ld_cnt;
  logic [PLEN_WIDTH-1:0]  r_prog_len;
  logic [DADDR_WIDTH-1:0] r_clr_cnt;
  logic                   r_core_resetq;

  logic [ST_WIDTH-1:0]    w_nxt_state;
  logic [CADDR_WIDTH-1:0] w_nxt_ld_cnt;
  logic [PLEN_WIDTH-1:0]  w_nxt_prog_len;
  logic [DADDR_WIDTH-1:0] w_nxt_clr_cnt;
  logic [CADDR_WIDTH-1:0] w_code_waddr;
  logic                   w_ld_ready;
  logic                   w_beat;
  logic                   w_clear;
  logic                   w_run;
  logic                   w_prog_end;

  // Abort blocks the loader so a beat can never race an abort.
  assign w_ld_ready = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && !abort;
  assign w_beat     = ld_valid && w_ld_ready;
  assign w_clear    = (r_state == ST_CLEAR);
  assign w_run      = (r_state == ST_RUN);
  assign w_prog_end = (PLEN_WIDTH'(core_code_addr) == r_prog_len);

  // Next-state and datapath update decisions.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_ld_cnt   = r_ld_cnt;
    w_nxt_prog_len = r_prog_len;
    w_nxt_clr_cnt  = '0;
    w_code_waddr   = r_ld_cnt;
    case (r_state)
      ST_IDLE: begin
        // A new program always starts at code address 0.
        w_code_waddr = '0;
        if (w_beat) begin
          w_nxt_ld_cnt = CADDR_WIDTH'(1);
          if (ld_last) begin
            w_nxt_prog_len = PLEN_WIDTH'(1);
            w_nxt_state    = ST_CLEAR;
          end else begin
            w_nxt_state    = ST_LOAD;
          end
        end else if (start && !abort && (r_prog_len != '0)) begin
          w_nxt_state = ST_CLEAR;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_nxt_prog_len = '0;
          w_nxt_state    = ST_IDLE;
        end else if (w_beat) begin
          w_nxt_ld_cnt = CADDR_WIDTH'(r_ld_cnt + CADDR_WIDTH'(1));
          // The last code address ends the program even without ld_last.
          if (ld_last || (r_ld_cnt == CODE_LAST)) begin
            w_nxt_prog_len = PLEN_WIDTH'(r_ld_cnt) + PLEN_WIDTH'(1);
            w_nxt_state    = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          w_nxt_state = ST_IDLE;
        end else if (r_clr_cnt == CLR_LAST) begin
          w_nxt_state = ST_RUN;
        end else begin
          w_nxt_clr_cnt = DADDR_WIDTH'(r_clr_cnt + DADDR_WIDTH'(1));
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_nxt_state = ST_IDLE;
        end else if (w_prog_end) begin
          w_nxt_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; core reset follows the next state.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state       <= ST_IDLE;
      r_ld_cnt      <= '0;
      r_prog_len    <= '0;
      r_clr_cnt     <= '0;
      r_core_resetq <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_ld_cnt      <= w_nxt_ld_cnt;
      r_prog_len    <= w_nxt_prog_len;
      r_clr_cnt     <= w_nxt_clr_cnt;
      r_core_resetq <= (w_nxt_state == ST_RUN);
    end
  end

  assign ld_ready    = w_ld_ready;
  assign busy        = st_busy(r_state);
  assign done        = (r_state == ST_DONE);
  assign core_resetq = r_core_resetq;

  assign code_we     = w_beat;
  assign code_waddr  = w_code_waddr;
  assign code_wdata  = ld_data;

  // Tape is zero-filled during CLEAR, otherwise owned by the core.
  assign tape_addr   = w_clear ? r_clr_cnt : core_mem_addr;
  assign tape_wdata  = w_clear ? '0 : core_mem_dout;
  assign tape_we     = w_clear || (w_run && core_mem_wr);

endmodule

// File: tb/tb_bf_run_ctrl.sv
// Directed self-checking bench for bf_run_ctrl.
module tb_bf_run_ctrl;
  import bf_run_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   resetq;
  logic                   ld_valid, ld_ready, ld_last, start, abort, busy, done;
  logic [DATA_WIDTH-1:0]  ld_data;
  logic                   code_we;
  logic [CADDR_WIDTH-1:0] code_waddr;
  logic [DATA_WIDTH-1:0]  code_wdata;
  logic                   core_resetq;
  logic [CADDR_WIDTH-1:0] core_code_addr;
  logic [DADDR_WIDTH-1:0] core_mem_addr;
  logic                   core_mem_wr;
  logic [DATA_WIDTH-1:0]  core_mem_dout;
  logic [DADDR_WIDTH-1:0] tape_addr;
  logic                   tape_we;
  logic [DATA_WIDTH-1:0]  tape_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  bf_run_ctrl dut (
    .clk(clk), .resetq(resetq),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .code_we(code_we), .code_waddr(code_waddr), .code_wdata(code_wdata),
    .core_resetq(core_resetq), .core_code_addr(core_code_addr),
    .core_mem_addr(core_mem_addr), .core_mem_wr(core_mem_wr), .core_mem_dout(core_mem_dout),
    .tape_addr(tape_addr), .tape_we(tape_we), .tape_wdata(tape_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l,
                       input logic s, input logic a);
    @(posedge clk);
    #1;
    ld_valid = v; ld_data = d; ld_last = l; start = s; abort = a;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        s;
    logic        a;
    logic        rdy;
    logic        we;
    logic [12:0] waddr;
    logic [7:0]  wdata;
    logic        bsy;
    logic        twe;
    logic [14:0] taddr;
    logic [7:0]  twdata;
  } vec_t;

  vec_t tbl[7];
  int   bad;
  int   n;

  initial begin
    // v      d   l   s   a  | rdy we  waddr  wdata bsy twe taddr  twdata
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 15'h1234, 8'h55};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 15'h1234, 8'h55};
    tbl[2] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 13'd0, 8'h01, 1'b0, 1'b0, 15'h1234, 8'h55};
    tbl[3] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 13'd1, 8'h02, 1'b1, 1'b0, 15'h1234, 8'h55};
    tbl[4] = '{1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'd2, 8'hAA, 1'b1, 1'b0, 15'h1234, 8'h55};
    tbl[5] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 13'd2, 8'h03, 1'b1, 1'b0, 15'h1234, 8'h55};
    tbl[6] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'd3, 8'h77, 1'b1, 1'b1, 15'h0000, 8'h00};

    resetq = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; start = 1'b0; abort = 1'b0;
    core_code_addr = '0;
    core_mem_addr = 15'h1234; core_mem_wr = 1'b1; core_mem_dout = 8'h55;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_core_resetq", 32'(core_resetq), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_tape_we", 32'(tape_we), 32'd0);
    @(posedge clk); #1 resetq = 1'b1;

    // Load 01,02,03(last); start with empty program ignored; beat beats start
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s, tbl[i].a);
      @(negedge clk);
      chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_code_we", i), 32'(code_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_code_waddr", i), 32'(code_waddr), 32'(tbl[i].waddr));
      chk($sformatf("v%0d_code_wdata", i), 32'(code_wdata), 32'(tbl[i].wdata));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("v%0d_tape_we", i), 32'(tape_we), 32'(tbl[i].twe));
      chk($sformatf("v%0d_tape_addr", i), 32'(tape_addr), 32'(tbl[i].taddr));
      chk($sformatf("v%0d_tape_wdata", i), 32'(tape_wdata), 32'(tbl[i].twdata));
      chk($sformatf("v%0d_done", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_core_resetq", i), 32'(core_resetq), 32'd0);
    end

    // Remaining clear sweep: addresses 1..32767, data 0, core held
    bad = 0;
    for (int i = 1; i < 32768; i++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (tape_we !== 1'b1 || tape_addr !== 15'(i) || tape_wdata !== 8'h00 ||
          core_resetq !== 1'b0 || busy !== 1'b1)
        bad++;
    end
    chk("clear_sweep_bad_cycles", 32'(bad), 32'd0);

    // First RUN cycle: core out of reset, tape mirrors core
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("run_core_resetq", 32'(core_resetq), 32'd1);
    chk("run_tape_we", 32'(tape_we), 32'd1);
    chk("run_tape_addr", 32'(tape_addr), 32'h1234);
    chk("run_tape_wdata", 32'(tape_wdata), 32'h55);
    chk("run_ld_ready", 32'(ld_ready), 32'd0);

    // Core steps through the program; ends when fetch address reaches 3
    core_mem_wr = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      @(posedge clk); #1 core_code_addr = 13'(a);
      @(negedge clk);
      chk($sformatf("run_step%0d_done", a), 32'(done), 32'd0);
      chk($sformatf("run_step%0d_core_resetq", a), 32'(core_resetq), 32'd1);
    end
    chk("run_tape_we_mirror0", 32'(tape_we), 32'd0);
    @(posedge clk); #1 core_code_addr = '0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_core_resetq", 32'(core_resetq), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_done_done", 32'(done), 32'd0);
    chk("post_done_busy", 32'(busy), 32'd0);

    // Rerun with retained program length
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("rerun_idle_busy", 32'(busy), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (core_resetq !== 1'b1 && n < 40000) begin
      if (tape_we === 1'b1) n++;
      @(negedge clk);
    end
    chk("rerun_clear_len", 32'(n), 32'd32768);
    chk("rerun_in_run", 32'(core_resetq), 32'd1);
    @(posedge clk); #1 core_code_addr = 13'd2;
    @(negedge clk);
    chk("rerun_addr2_done", 32'(done), 32'd0);
    @(posedge clk); #1 core_code_addr = 13'd3;
    @(negedge clk);
    chk("rerun_addr3_done", 32'(done), 32'd0);
    @(posedge clk); #1 core_code_addr = '0;
    @(negedge clk);
    chk("rerun_done_pulse", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Abort at CLEAR cycle 100
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (100) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_clr_addr", 32'(tape_addr), 32'd100);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_clr_busy", 32'(busy), 32'd0);
    chk("abort_clr_done", 32'(done), 32'd0);
    chk("abort_clr_core_resetq", 32'(core_resetq), 32'd0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0 || core_resetq !== 1'b0) bad++;
    end
    chk("abort_clr_quiet", 32'(bad), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_keeps_len", 32'(busy), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_clr2_busy", 32'(busy), 32'd0);

    // Abort in LOAD wipes the program length
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("abort_ld_ready", 32'(ld_ready), 32'd0);
    chk("abort_ld_code_we", 32'(code_we), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("abort_ld_idle", 32'(busy), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_ld_start_ignored", 32'(busy), 32'd0);

    // 8192 beats with no ld_last
    bad = 0;
    core_mem_wr = 1'b1;
    for (int i = 0; i < 8192; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (code_we !== 1'b1 || code_waddr !== 13'(i) || code_wdata !== 8'(i)) bad++;
      if (i == 8191) chk("full_last_waddr", 32'(code_waddr), 32'd8191);
    end
    chk("full_load_bad", 32'(bad), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_clear_we", 32'(tape_we), 32'd1);
    chk("full_clear_addr", 32'(tape_addr), 32'd0);
    chk("full_clear_ready", 32'(ld_ready), 32'd0);

    // Asynchronous reset mid-CLEAR
    repeat (50) @(posedge clk);
    #2 resetq = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_core_resetq", 32'(core_resetq), 32'd0);
    chk("midrst_tape_we", 32'(tape_we), 32'd0);
    chk("midrst_tape_addr", 32'(tape_addr), 32'h1234);
    chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk); #1 resetq = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_len_cleared", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
